// File: rtl/seg_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller.
package seg_pkg;

   typedef enum logic [1:0] {StOff, StBlank, StDrive} seg_state_e;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

   function automatic logic [NUM_DIGITS-1:0] an_onecold(input logic [1:0] idx);
      logic [NUM_DIGITS-1:0] pattern;
      pattern = AN_OFF;
      pattern[idx] = 1'b0;
      return pattern;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module seg_scan_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] load_val,
   output logic             done
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit display scanner: per-frame snapshot, blanking gap between digits,
// leading-zero suppression and registered anode/dp/nibble outputs.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DIGIT_CYC = 100000,
   parameter int unsigned BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic [3:0]  dp_en,
   input  logic        lz_en,
   output logic [3:0]  nibble,
   output logic [3:0]  an,
   output logic        dp,
   output logic [1:0]  digit_idx,
   output logic        frame_tick
);

   localparam int unsigned MaxCyc = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
   localparam int unsigned CntW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
   localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYC - 1);
   localparam logic [CntW-1:0] DriveLoad = CntW'(DIGIT_CYC - 1);

   seg_state_e  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        start_q;
   logic [15:0] snap_value_q;
   logic [3:0]  snap_dp_q;
   logic        snap_lz_q;
   logic [3:0]  an_q, nibble_q;
   logic        dp_q, frame_tick_q;

   logic            leave;
   logic            new_frame;
   logic [CntW-1:0] load_val;
   logic            tmr_done;
   logic [3:0]      lz_mask;

   seg_scan_timer #(
      .Width (CntW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (leave),
      .load_val (load_val),
      .done     (tmr_done)
   );

   // start_q marks the first cycle out of reset, which opens a fresh frame.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      leave   = 1'b0;
      if (!enable) begin
         state_d = StOff;
         leave   = (state_q != StOff);
      end else if (state_q == StOff || start_q) begin
         state_d = StBlank;
         idx_d   = 2'd0;
         leave   = 1'b1;
      end else if (tmr_done) begin
         leave = 1'b1;
         if (state_q == StBlank) begin
            state_d = StDrive;
         end else begin
            state_d = StBlank;
            idx_d   = idx_q + 2'd1;
         end
      end
      new_frame = leave && (state_d == StBlank) && (idx_d == 2'd0);
      case (state_d)
         StBlank: load_val = BlankLoad;
         StDrive: load_val = DriveLoad;
         default: load_val = '0;
      endcase
   end

   // A digit above 0 stays dark when it and every higher digit are zero.
   always_comb begin
      lz_mask = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         lz_mask[i] = snap_lz_q && ((snap_value_q >> (4 * i)) == 16'h0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StBlank;
         idx_q        <= 2'd0;
         start_q      <= 1'b1;
         snap_value_q <= '0;
         snap_dp_q    <= '0;
         snap_lz_q    <= 1'b0;
         an_q         <= AN_OFF;
         dp_q         <= 1'b1;
         nibble_q     <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         start_q      <= 1'b0;
         frame_tick_q <= new_frame;
         if (new_frame) begin
            snap_value_q <= value;
            snap_dp_q    <= dp_en;
            snap_lz_q    <= lz_en;
         end
         if (state_d == StDrive) begin
            an_q     <= lz_mask[idx_d] ? AN_OFF : an_onecold(idx_d);
            dp_q     <= ~snap_dp_q[idx_d];
            nibble_q <= snap_value_q[{idx_d, 2'b00} +: 4];
         end else begin
            an_q <= AN_OFF;
            dp_q <= 1'b1;
         end
      end
   end

   assign an         = an_q;
   assign dp         = dp_q;
   assign nibble     = nibble_q;
   assign digit_idx  = idx_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGIT_CYC=4, BLANK_CYC=2 (24-cycle frame).
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  dp_en;
   logic        lz_en;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic        dp;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int tests = 0;
   int fails = 0;

   seg_scan_ctrl #(
      .DIGIT_CYC (4),
      .BLANK_CYC (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .value      (value),
      .dp_en      (dp_en),
      .lz_en      (lz_en),
      .nibble     (nibble),
      .an         (an),
      .dp         (dp),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks one whole frame; the caller has already sampled frame cycle 0.
   task automatic check_frame(input string name, input logic [15:0] v, input logic [3:0] dpm,
                              input logic lz, input int chg_at, input logic [15:0] chg_val);
      int         slot;
      int         pos;
      logic       sup;
      logic       exp_dp;
      logic       exp_tick;
      logic [3:0] exp_an;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         slot     = k / 6;
         pos      = k % 6;
         sup      = lz && (slot >= 1) && ((v >> (4 * slot)) == 16'h0);
         exp_an   = 4'hF;
         if (pos >= 2 && !sup) exp_an[slot] = 1'b0;
         exp_dp   = (pos >= 2) ? ~dpm[slot] : 1'b1;
         exp_tick = (k == 0);
         chk($sformatf("%s an k=%0d", name, k), {12'h0, an}, {12'h0, exp_an});
         chk($sformatf("%s idx k=%0d", name, k), {14'h0, digit_idx}, 16'(slot));
         chk($sformatf("%s tick k=%0d", name, k), {15'h0, frame_tick}, {15'h0, exp_tick});
         chk($sformatf("%s dp k=%0d", name, k), {15'h0, dp}, {15'h0, exp_dp});
         if (pos >= 2 && !sup)
            chk($sformatf("%s nibble k=%0d", name, k), {12'h0, nibble}, {12'h0, v[slot*4 +: 4]});
         if (k == chg_at) value = chg_val;
      end
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      value  = 16'h1234;
      dp_en  = 4'b0000;
      lz_en  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset an", {12'h0, an}, 16'h000F);
      chk("reset dp", {15'h0, dp}, 16'h0001);
      chk("reset nibble", {12'h0, nibble}, 16'h0000);
      chk("reset tick", {15'h0, frame_tick}, 16'h0000);
      chk("reset idx", {14'h0, digit_idx}, 16'h0000);

      // Basic scan, with a mid-frame value change that must not tear.
      rst = 1'b0;
      @(negedge clk);
      check_frame("f1234", 16'h1234, 4'b0000, 1'b0, 10, 16'h5678);
      @(negedge clk);
      check_frame("f5678", 16'h5678, 4'b0000, 1'b0, -1, 16'h0);

      // Leading-zero suppression and decimal point on a suppressed digit.
      lz_en = 1'b1;
      value = 16'h0070;
      dp_en = 4'b0100;
      @(negedge clk);
      check_frame("lz0070", 16'h0070, 4'b0100, 1'b1, -1, 16'h0);
      value = 16'h0000;
      dp_en = 4'b0000;
      @(negedge clk);
      check_frame("lz0000", 16'h0000, 4'b0000, 1'b1, -1, 16'h0);

      // Enable dropped during digit 2's drive slot.
      lz_en = 1'b0;
      value = 16'h1234;
      @(negedge clk);
      repeat (14) @(negedge clk);
      chk("pre-off an", {12'h0, an}, 16'h000B);
      chk("pre-off idx", {14'h0, digit_idx}, 16'h0002);
      enable = 1'b0;
      @(negedge clk);
      chk("off an", {12'h0, an}, 16'h000F);
      chk("off dp", {15'h0, dp}, 16'h0001);
      chk("off tick", {15'h0, frame_tick}, 16'h0000);
      enable = 1'b1;
      value  = 16'hABCD;
      @(negedge clk);
      check_frame("reen", 16'hABCD, 4'b0000, 1'b0, -1, 16'h0);

      // Reset pulse during digit 3's drive slot.
      @(negedge clk);
      repeat (20) @(negedge clk);
      chk("pre-rst an", {12'h0, an}, 16'h0007);
      chk("pre-rst idx", {14'h0, digit_idx}, 16'h0003);
      chk("pre-rst nibble", {12'h0, nibble}, 16'h000A);
      rst   = 1'b1;
      value = 16'h9F31;
      @(negedge clk);
      chk("rst an", {12'h0, an}, 16'h000F);
      chk("rst idx", {14'h0, digit_idx}, 16'h0000);
      chk("rst dp", {15'h0, dp}, 16'h0001);
      chk("rst nibble", {12'h0, nibble}, 16'h0000);
      chk("rst tick", {15'h0, frame_tick}, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      check_frame("post-rst", 16'h9F31, 4'b0000, 1'b0, -1, 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
